// File: rtl/pipeline_control_pkg.sv
// Shared definitions for the decode-stage hazard controller: register-file
// geometry, FSM state encoding and the register-address decoder.
package pipeline_control_pkg;

  localparam int NREGS  = 16;
  localparam int REG_AW = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    SHADOW = 1'b1
  } state_t;

  // Decode a register address into a one-bit-per-register mask.
  function automatic logic [NREGS-1:0] onehot(input logic [REG_AW-1:0] addr);
    logic [NREGS-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/pipeline_control_scoreboard.sv
// Load scoreboard: one pending bit per register plus a running count of
// loads in flight. A completing load is removed from the effective view in
// the same cycle so the consumer can forward instead of stalling.
module pc_scoreboard
  import pipeline_control_pkg::*;
#(
  parameter int MAX_LOADS = 2,
  parameter int LW        = $clog2(MAX_LOADS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clear,
  input  logic [REG_AW-1:0] clear_addr,
  output logic [NREGS-1:0]  pend_eff,
  output logic              clr_hit,
  output logic [NREGS-1:0]  pending,
  output logic [LW-1:0]     loads_inflight
);

  logic [NREGS-1:0] clr_mask;
  logic [NREGS-1:0] set_mask;

  // A completion only counts when it targets a register that is pending.
  assign clr_mask = clear ? (onehot(clear_addr) & pending) : '0;
  assign clr_hit  = |clr_mask;
  assign pend_eff = pending & ~clr_mask;
  assign set_mask = set ? onehot(set_addr) : '0;

  // Scoreboard state: set wins over clear, the count tracks popcount(pending).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending        <= '0;
      loads_inflight <= '0;
    end else begin
      pending <= pend_eff | set_mask;
      case ({set, clr_hit})
        2'b10:   loads_inflight <= loads_inflight + LW'(1);
        2'b01:   loads_inflight <= loads_inflight - LW'(1);
        default: loads_inflight <= loads_inflight;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_control.sv
// Decode-stage hazard and sequencing controller. Stalls decode on load-use
// and write-after-write hazards against loads in flight, limits the number
// of outstanding loads, and bubbles the slots fetched behind a taken jump.
module pipeline_control
  import pipeline_control_pkg::*;
#(
  parameter int MAX_LOADS   = 2,
  parameter int JUMP_SHADOW = 2,
  parameter int LW          = $clog2(MAX_LOADS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_valid,
  input  logic [NREGS-1:0]  dec_rd_mask,
  input  logic [REG_AW-1:0] dec_dest,
  input  logic              dec_writes,
  input  logic              dec_is_mem,
  input  logic              dec_mem_write,
  input  logic              dec_is_jump,
  input  logic              mem_done,
  input  logic [REG_AW-1:0] mem_done_addr,
  output logic              issue,
  output logic              stall,
  output logic              bubble,
  output logic [NREGS-1:0]  pending,
  output logic [LW-1:0]     loads_inflight,
  output logic              in_shadow
);

  localparam logic [2:0] SHADOW_INIT = 3'(JUMP_SHADOW);

  state_t           state, state_d;
  logic [2:0]       shadow_cnt, shadow_cnt_d;
  logic [NREGS-1:0] pend_eff;
  logic [NREGS-1:0] dmask;
  logic             clr_hit;
  logic             is_load;
  logic             hazard;
  logic             sb_set;
  logic             jump_take;

  assign is_load = dec_is_mem & ~dec_mem_write;
  assign dmask   = dec_writes ? onehot(dec_dest) : '0;

  // Reads or the destination hitting a still-pending load, or a new load
  // with every load slot busy and none retiring this cycle.
  assign hazard = (|((dec_rd_mask | dmask) & pend_eff))
                | (is_load & (loads_inflight == LW'(MAX_LOADS)) & ~clr_hit);

  assign sb_set    = issue & is_load & dec_writes;
  assign jump_take = issue & dec_is_jump & (JUMP_SHADOW != 0);
  assign in_shadow = (state == SHADOW);

  pc_scoreboard #(
    .MAX_LOADS (MAX_LOADS),
    .LW        (LW)
  ) u_scoreboard (
    .clk            (clk),
    .rst_n          (rst_n),
    .set            (sb_set),
    .set_addr       (dec_dest),
    .clear          (mem_done),
    .clear_addr     (mem_done_addr),
    .pend_eff       (pend_eff),
    .clr_hit        (clr_hit),
    .pending        (pending),
    .loads_inflight (loads_inflight)
  );

  // FSM state and jump-shadow counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shadow_cnt <= '0;
    end else begin
      state      <= state_d;
      shadow_cnt <= shadow_cnt_d;
    end
  end

  // Next state: enter SHADOW on an issued jump, leave after the last slot.
  always_comb begin
    state_d      = state;
    shadow_cnt_d = shadow_cnt;
    case (state)
      IDLE: begin
        if (jump_take) begin
          state_d      = SHADOW;
          shadow_cnt_d = SHADOW_INIT;
        end
      end
      SHADOW: begin
        shadow_cnt_d = shadow_cnt - 3'd1;
        if (shadow_cnt == 3'd1) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d      = IDLE;
        shadow_cnt_d = '0;
      end
    endcase
  end

  // Decode handshake: squash everything in the shadow, otherwise issue or hold.
  always_comb begin
    issue  = 1'b0;
    stall  = 1'b0;
    bubble = 1'b1;
    if (state == IDLE) begin
      issue  = dec_valid & ~hazard;
      stall  = dec_valid & hazard;
      bubble = ~(dec_valid & ~hazard);
    end
  end

endmodule
